single_dot_product: RTL and testbench

//  Initiator-side sequencer for the single-precision multiply-accumulate unit: accepts a stream of

---
 rtl/single_pkg.sv | 16 +
 rtl/single_dot_product_if.sv | 24 ++
 rtl/single_multiply_accumulate.sv | 149 ++++++++++++++
 rtl/single_dot_product.sv | 108 ++++++++++
 tb/tb_single_dot_product.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/single_pkg.sv
// Shared types and constants for the single-precision dot-product slice.
package single_pkg;

   // Controller phases of one dot-product vector.
   typedef enum logic [1:0] {
      CLEAR  = 2'd0,
      ACCUM  = 2'd1,
      DRAIN  = 2'd2,
      OUTPUT = 2'd3
   } dot_state_t;

   localparam logic [31:0] FP_ZERO = 32'h0000_0000;
   localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
   localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/single_dot_product_if.sv
// Operand stream in, result stream out, both valid/ready.
interface single_dot_product_if #(
   parameter int CNT_W = 16
);
   logic             s_valid;
   logic             s_ready;
   logic [31:0]      s_a;
   logic [31:0]      s_b;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [31:0]      m_data;
   logic [CNT_W-1:0] m_count;

   modport master (
      output s_valid, s_a, s_b, s_last, m_ready,
      input  s_ready, m_valid, m_data, m_count
   );

   modport slave (
      input  s_valid, s_a, s_b, s_last, m_ready,
      output s_ready, m_valid, m_data, m_count
   );
endinterface

// File: rtl/single_multiply_accumulate.sv
// Single-precision MAC: one registered multiply stage feeding an accumulator.
// Round-to-nearest-even; denormal inputs and underflowing results flush to zero.
module single_multiply_accumulate
   import single_pkg::*;
(
   input  logic        clk,
   input  logic        rstn,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] c
);

   logic [31:0] prod;
   logic        prod_valid;
   logic [31:0] acc;

   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic               sign;
      logic [47:0]        p;
      logic [23:0]        man;
      logic [24:0]        mr;
      logic               g;
      logic               st;
      logic signed [9:0]  e;
      sign = x[31] ^ y[31];
      if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
          (x[30:23] == 8'hFF && y[30:23] == 8'h00) || (y[30:23] == 8'hFF && x[30:23] == 8'h00))
         return FP_QNAN;
      if (x[30:23] == 8'hFF || y[30:23] == 8'hFF)
         return {sign, 8'hFF, 23'd0};
      if (x[30:23] == 8'h00 || y[30:23] == 8'h00)
         return {sign, 31'd0};
      p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
      e = $signed({2'b00, x[30:23]}) + $signed({2'b00, y[30:23]}) - 10'sd127;
      if (p[47]) begin
         man = p[47:24];
         g   = p[23];
         st  = |p[22:0];
         e   = e + 10'sd1;
      end else begin
         man = p[46:23];
         g   = p[22];
         st  = |p[21:0];
      end
      mr = {1'b0, man};
      if (g && (st || man[0]))
         mr = mr + 25'd1;
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'sd1;
      end
      if (e >= 10'sd255)
         return {sign, 8'hFF, 23'd0};
      if (e <= 10'sd0)
         return {sign, 31'd0};
      return {sign, e[7:0], mr[22:0]};
   endfunction

   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic [31:0]        big;
      logic [31:0]        sml;
      logic [7:0]         d;
      logic [26:0]        mb;
      logic [26:0]        ms;
      logic [26:0]        lost;
      logic [27:0]        s;
      logic [24:0]        mr;
      logic signed [9:0]  e;
      if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0) ||
          (x[30:23] == 8'hFF && y[30:23] == 8'hFF && x[31] != y[31]))
         return FP_QNAN;
      if (x[30:23] == 8'hFF)
         return x;
      if (y[30:23] == 8'hFF)
         return y;
      if (x[30:23] == 8'h00)
         return (y[30:23] == 8'h00) ? {x[31] & y[31], 31'd0} : y;
      if (y[30:23] == 8'h00)
         return x;
      if (x[30:0] >= y[30:0]) begin
         big = x;
         sml = y;
      end else begin
         big = y;
         sml = x;
      end
      d  = big[30:23] - sml[30:23];
      mb = {1'b1, big[22:0], 3'b000};
      ms = {1'b1, sml[22:0], 3'b000};
      if (d > 8'd26) begin
         ms = 27'd1;
      end else begin
         lost = ms & ((27'd1 << d) - 27'd1);
         ms   = (ms >> d) | {26'd0, |lost};
      end
      e = $signed({2'b00, big[30:23]});
      if (big[31] == sml[31]) begin
         s = {1'b0, mb} + {1'b0, ms};
         if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
         end
      end else begin
         s = {1'b0, mb} - {1'b0, ms};
         if (s == 28'd0)
            return FP_ZERO;
         for (int i = 0; i < 26; i++) begin
            if (!s[26]) begin
               s = s << 1;
               e = e - 10'sd1;
            end
         end
      end
      mr = {1'b0, s[26:3]};
      if (s[2] && (s[1] || s[0] || s[3]))
         mr = mr + 25'd1;
      if (mr[24]) begin
         mr = mr >> 1;
         e  = e + 10'sd1;
      end
      if (e >= 10'sd255)
         return {big[31], 8'hFF, 23'd0};
      if (e <= 10'sd0)
         return {big[31], 31'd0};
      return {big[31], e[7:0], mr[22:0]};
   endfunction

   // Product stage then accumulate stage; clear zeroes the running sum for a new vector.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         prod       <= FP_ZERO;
         prod_valid <= 1'b0;
         acc        <= FP_ZERO;
      end else begin
         prod_valid <= in_valid;
         if (in_valid)
            prod <= fp_mul(a, b);
         if (clear)
            acc <= FP_ZERO;
         else if (prod_valid)
            acc <= fp_add(acc, prod);
      end
   end

   assign c = acc;

endmodule

// File: rtl/single_dot_product.sv
// Sequencer that frames operand pairs into MAC vectors and returns one dot product per vector.
module single_dot_product
   import single_pkg::*;
#(
   parameter int DRAIN_CYCLES = 6,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rstn,
   single_dot_product_if.slave   bus
);

   localparam int DW = $clog2(DRAIN_CYCLES + 1);

   dot_state_t       state;
   dot_state_t       state_nxt;
   logic             accept;
   logic             mac_clear;
   logic             mac_in_valid;
   logic [31:0]      mac_a;
   logic [31:0]      mac_b;
   logic [31:0]      mac_c;
   logic [CNT_W-1:0] term_cnt;
   logic [DW-1:0]    drain_cnt;
   logic [31:0]      m_data_q;
   logic [CNT_W-1:0] m_count_q;

   assign bus.s_ready = (state == ACCUM);
   assign bus.m_valid = (state == OUTPUT);
   assign bus.m_data  = m_data_q;
   assign bus.m_count = m_count_q;
   assign accept      = bus.s_valid && (state == ACCUM);

   // State register; reset abandons whatever vector was in progress.
   always_ff @(posedge clk) begin
      if (!rstn)
         state <= CLEAR;
      else
         state <= state_nxt;
   end

   // Phase sequencing and the MAC clear strobe.
   always_comb begin
      state_nxt = state;
      mac_clear = 1'b0;
      case (state)
         CLEAR: begin
            mac_clear = 1'b1;
            state_nxt = ACCUM;
         end
         ACCUM: begin
            if (accept && bus.s_last)
               state_nxt = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt == '0)
               state_nxt = OUTPUT;
         end
         OUTPUT: begin
            if (bus.m_ready)
               state_nxt = CLEAR;
         end
         default: state_nxt = CLEAR;
      endcase
   end

   // Issue registers, term/drain counters and the held result.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         mac_in_valid <= 1'b0;
         mac_a        <= FP_ZERO;
         mac_b        <= FP_ZERO;
         term_cnt     <= '0;
         drain_cnt    <= '0;
         m_data_q     <= FP_ZERO;
         m_count_q    <= '0;
      end else begin
         mac_in_valid <= accept;
         if (accept) begin
            mac_a <= bus.s_a;
            mac_b <= bus.s_b;
         end
         if (state == CLEAR)
            term_cnt <= '0;
         else if (accept && term_cnt != '1)
            term_cnt <= term_cnt + 1'b1;
         if (accept && bus.s_last)
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
         else if (state == DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - 1'b1;
         if (state == DRAIN && drain_cnt == '0) begin
            m_data_q  <= mac_c;
            m_count_q <= term_cnt;
         end
      end
   end

   single_multiply_accumulate mac0 (
      .clk      (clk),
      .rstn     (rstn),
      .clear    (mac_clear),
      .in_valid (mac_in_valid),
      .a        (mac_a),
      .b        (mac_b),
      .c        (mac_c)
   );

endmodule

// File: tb/tb_single_dot_product.sv
// Directed bench for single_dot_product: table of vectors plus reset/latency/backpressure sequences.
module tb_single_dot_product;
   import single_pkg::*;

   localparam int DRAIN_CYCLES = 6;
   localparam int CNT_W        = 16;

   typedef struct {
      int               n;
      int               gap;
      logic [3:0][31:0] a;
      logic [3:0][31:0] b;
      logic [31:0]      exp_data;
      logic [CNT_W-1:0] exp_count;
   } vec_t;

   logic clk;
   logic rstn;
   int   checks;
   int   errors;
   vec_t tbl [8];

   single_dot_product_if #(.CNT_W(CNT_W)) bus ();

   single_dot_product #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic setVec(input int idx, input int n, input int gap,
                         input logic [31:0] a0, input logic [31:0] b0,
                         input logic [31:0] a1, input logic [31:0] b1,
                         input logic [31:0] a2, input logic [31:0] b2,
                         input logic [31:0] a3, input logic [31:0] b3,
                         input logic [31:0] exp_data, input int exp_count);
      tbl[idx].n         = n;
      tbl[idx].gap       = gap;
      tbl[idx].a         = {a3, a2, a1, a0};
      tbl[idx].b         = {b3, b2, b1, b0};
      tbl[idx].exp_data  = exp_data;
      tbl[idx].exp_count = CNT_W'(exp_count);
   endtask

   task automatic sendBeat(input logic [31:0] a, input logic [31:0] b, input logic last);
      int guard;
      guard = 0;
      bus.s_valid = 1'b1;
      bus.s_a     = a;
      bus.s_b     = b;
      bus.s_last  = last;
      while (!bus.s_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!bus.s_ready)
         checkOutput("s_ready_wait", 32'(bus.s_ready), 32'd1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
   endtask

   task automatic waitResult(input string name);
      int guard;
      guard = 0;
      while (!bus.m_valid && guard < 60) begin
         @(negedge clk);
         guard++;
      end
      checkOutput({name, "_m_valid"}, 32'(bus.m_valid), 32'd1);
   endtask

   task automatic takeResult(input string name, input logic [31:0] exp_data, input logic [CNT_W-1:0] exp_count);
      checkOutput({name, "_data"}, bus.m_data, exp_data);
      checkOutput({name, "_count"}, 32'(bus.m_count), 32'(exp_count));
      bus.m_ready = 1'b1;
      @(negedge clk);
      bus.m_ready = 1'b0;
      checkOutput({name, "_m_valid_drop"}, 32'(bus.m_valid), 32'd0);
   endtask

   task automatic applyStimulus(input int idx);
      string name;
      name = $sformatf("vec%0d", idx);
      for (int i = 0; i < tbl[idx].n; i++) begin
         sendBeat(tbl[idx].a[i], tbl[idx].b[i], i == tbl[idx].n - 1);
         if (i != tbl[idx].n - 1)
            repeat (tbl[idx].gap) @(negedge clk);
      end
      waitResult(name);
      takeResult(name, tbl[idx].exp_data, tbl[idx].exp_count);
   endtask

   initial begin
      int cycles;
      logic acc_edge;
      checks      = 0;
      errors      = 0;
      rstn        = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_a     = '0;
      bus.s_b     = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;

      setVec(0, 2, 0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000, 0, 0, 0, 0, 32'h4160_0000, 2);
      setVec(1, 4, 3, FP_ONE, FP_ONE, FP_ONE, FP_ONE, FP_ONE, FP_ONE, FP_ONE, FP_ONE, 32'h4080_0000, 4);
      setVec(2, 1, 0, 32'h4000_0000, 32'h4000_0000, 0, 0, 0, 0, 0, 0, 32'h4080_0000, 1);
      setVec(3, 1, 0, FP_ONE, FP_ONE, 0, 0, 0, 0, 0, 0, FP_ONE, 1);
      setVec(4, 1, 0, 32'hC000_0000, 32'h4040_0000, 0, 0, 0, 0, 0, 0, 32'hC0C0_0000, 1);
      setVec(5, 2, 0, 32'h3F00_0000, 32'h3F00_0000, 32'h3E80_0000, 32'h4080_0000, 0, 0, 0, 0, 32'h3FA0_0000, 2);
      setVec(6, 3, 1, 32'h4000_0000, 32'h4040_0000, 32'hBF80_0000, 32'h4080_0000, 32'h3F00_0000, 32'h4000_0000, 0, 0, 32'h4040_0000, 3);
      setVec(7, 2, 0, FP_ONE, FP_ONE, 32'hBF80_0000, FP_ONE, 0, 0, 0, 0, FP_ZERO, 2);

      repeat (3) @(negedge clk);
      checkOutput("reset_s_ready", 32'(bus.s_ready), 32'd0);
      checkOutput("reset_m_valid", 32'(bus.m_valid), 32'd0);
      checkOutput("reset_m_data", bus.m_data, FP_ZERO);
      checkOutput("reset_m_count", 32'(bus.m_count), 32'd0);

      // Single term straight out of reset: CLEAR, accept, then the drain window.
      $display("[TB] single-term latency");
      rstn        = 1'b1;
      bus.s_valid = 1'b1;
      bus.s_a     = 32'h3FC0_0000;
      bus.s_b     = 32'h4000_0000;
      bus.s_last  = 1'b1;
      cycles      = 0;
      do begin
         acc_edge = bus.s_ready && bus.s_valid;
         @(negedge clk);
         cycles++;
         if (acc_edge) begin
            bus.s_valid = 1'b0;
            bus.s_last  = 1'b0;
         end
      end while (!bus.m_valid && cycles < 40);
      checkOutput("t2_latency", 32'(cycles), 32'(2 + DRAIN_CYCLES));
      takeResult("t2", 32'h4040_0000, CNT_W'(1));

      $display("[TB] vector table");
      for (int i = 0; i < 8; i++)
         applyStimulus(i);

      // Held result under backpressure, with upstream offering data the whole time.
      $display("[TB] output backpressure");
      sendBeat(32'h4000_0000, 32'h4040_0000, 1'b1);
      waitResult("t4");
      bus.s_valid = 1'b1;
      bus.s_a     = 32'h4120_0000;
      bus.s_b     = 32'h4120_0000;
      for (int i = 0; i < 10; i++) begin
         checkOutput("t4_hold_m_valid", 32'(bus.m_valid), 32'd1);
         checkOutput("t4_hold_m_data", bus.m_data, 32'h40C0_0000);
         checkOutput("t4_hold_s_ready", 32'(bus.s_ready), 32'd0);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      takeResult("t4", 32'h40C0_0000, CNT_W'(1));

      // Abort a vector part-way; its partial sum must not leak into the next one.
      $display("[TB] reset mid-vector");
      sendBeat(32'h4000_0000, 32'h4000_0000, 1'b0);
      sendBeat(32'h4000_0000, 32'h4000_0000, 1'b0);
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("t6_reset_s_ready", 32'(bus.s_ready), 32'd0);
      checkOutput("t6_reset_m_valid", 32'(bus.m_valid), 32'd0);
      checkOutput("t6_reset_m_data", bus.m_data, FP_ZERO);
      checkOutput("t6_reset_m_count", 32'(bus.m_count), 32'd0);
      rstn = 1'b1;
      sendBeat(FP_ONE, 32'h4040_0000, 1'b1);
      waitResult("t6");
      takeResult("t6", 32'h4040_0000, CNT_W'(1));

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
